// File: rtl/angle_entry_parser.sv
// Assembles a decimal angle from received ASCII bytes and presents it with a valid strobe.
module angle_entry_parser #(
  parameter int unsigned MAXANG  = 90,
  parameter logic [7:0]  TERM    = 8'h0D,
  parameter int unsigned TIMEOUT = 50000000
) (
  input  logic       CLK,
  input  logic       RSTN,
  input  logic       rdrdy,
  input  logic [7:0] rbr,
  output logic [6:0] dataout,
  output logic       dav,
  output logic       err,
  output logic [6:0] LED
);

  localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ONE  = 2'd1,
    TWO  = 2'd2,
    DISC = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic          s1_q, s2_q, s3_q;
  logic [6:0]    acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [6:0]    dout_q, dout_d;
  logic          dav_q, dav_d;
  logic          err_q, err_d;

  logic          strb_c;
  logic          is_dig_c;
  logic          is_trm_c;
  logic [6:0]    digit_c;
  logic [6:0]    acc_next_c;

  // Rising edge of the synchronised data-ready level marks one new byte.
  assign strb_c     = s2_q & ~s3_q;
  assign is_dig_c   = (rbr >= 8'h30) && (rbr <= 8'h39);
  assign is_trm_c   = (rbr == TERM);
  assign digit_c    = {3'b000, rbr[3:0]};
  assign acc_next_c = 7'(acc_q * 7'd10) + digit_c;

  // Synchroniser, entry state, accumulator, timeout counter and output registers.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      s3_q    <= 1'b0;
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      dout_q  <= '0;
      dav_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      s1_q    <= rdrdy;
      s2_q    <= s1_q;
      s3_q    <= s2_q;
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      dav_q   <= dav_d;
      err_q   <= err_d;
    end
  end

  // Next-state, accumulation, commit decision and inactivity timeout.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    dav_d   = 1'b0;
    err_d   = 1'b0;

    if (strb_c) begin
      cnt_d = '0;
      unique case (state_q)
        IDLE: begin
          if (is_dig_c) begin
            acc_d   = digit_c;
            state_d = ONE;
          end else if (!is_trm_c) begin
            err_d   = 1'b1;
            acc_d   = '0;
            state_d = DISC;
          end
        end
        ONE, TWO: begin
          if (is_dig_c && state_q == ONE) begin
            acc_d   = acc_next_c;
            state_d = TWO;
          end else if (is_trm_c) begin
            // Commit: accept in-range values, reject the rest without touching dataout.
            if (32'(acc_q) <= MAXANG) begin
              dout_d = acc_q;
              dav_d  = 1'b1;
            end else begin
              err_d = 1'b1;
            end
            acc_d   = '0;
            state_d = IDLE;
          end else begin
            err_d   = 1'b1;
            acc_d   = '0;
            state_d = DISC;
          end
        end
        DISC: begin
          if (is_trm_c) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q == IDLE) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      // Stale partial entry: drop it silently.
      state_d = IDLE;
      acc_d   = '0;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  assign dataout = dout_q;
  assign LED     = dout_q;
  assign dav     = dav_q;
  assign err     = err_q;

endmodule

// File: tb/tb_angle_entry_parser.sv
// Self-checking bench for angle_entry_parser against a string-level entry model.
module tb_angle_entry_parser;

  localparam int unsigned TO   = 100;
  localparam logic [7:0]  CR   = 8'h0D;
  localparam int          MAXA = 90;

  logic       clk;
  logic       rst_n;
  logic       rdrdy;
  logic [7:0] rbr;
  logic [6:0] dataout;
  logic       dav;
  logic       err;
  logic [6:0] led;

  int checks;
  int failures;
  int dav_cnt;
  int err_cnt;
  int both_cnt;

  // Reference model: pending digits of the current line, discard flag, last accepted angle.
  int unsigned digs[$];
  bit          disc;
  int          model_out;

  angle_entry_parser #(
    .MAXANG (MAXA),
    .TERM   (CR),
    .TIMEOUT(TO)
  ) dut (
    .CLK    (clk),
    .RSTN   (rst_n),
    .rdrdy  (rdrdy),
    .rbr    (rbr),
    .dataout(dataout),
    .dav    (dav),
    .err    (err),
    .LED    (led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count strobe cycles away from the active edge.
  always @(negedge clk) begin
    if (dav) dav_cnt++;
    if (err) err_cnt++;
    if (dav && err) both_cnt++;
  end

  task automatic model_clear();
    digs.delete();
    disc = 1'b0;
  endtask

  // Apply one received byte to the line model; report which pulse it should produce.
  task automatic model_byte(input logic [7:0] b, output int exp_dav, output int exp_err);
    int val;
    exp_dav = 0;
    exp_err = 0;
    if (disc) begin
      if (b == CR) model_clear();
    end else if (b >= 8'h30 && b <= 8'h39) begin
      if (digs.size() == 2) begin
        exp_err = 1;
        model_clear();
        disc = 1'b1;
      end else begin
        digs.push_back(int'(b) - 48);
      end
    end else if (b == CR) begin
      if (digs.size() != 0) begin
        val = 0;
        foreach (digs[i]) val = val * 10 + int'(digs[i]);
        if (val <= MAXA) begin
          exp_dav   = 1;
          model_out = val;
        end else begin
          exp_err = 1;
        end
      end
      model_clear();
    end else begin
      exp_err = 1;
      model_clear();
      disc = 1'b1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int hold, input int low, input string tag);
    int d0, e0, xd, xe;
    d0 = dav_cnt;
    e0 = err_cnt;
    model_byte(b, xd, xe);
    rbr   = b;
    rdrdy = 1'b1;
    repeat (hold) @(posedge clk);
    rdrdy = 1'b0;
    repeat (low) @(posedge clk);
    if (hold >= int'(TO)) model_clear();
    @(negedge clk);
    checks++;
    if (dav_cnt - d0 !== xd) begin
      failures++;
      $display("FAIL %s dav byte=%h got=%0d want=%0d", tag, b, dav_cnt - d0, xd);
    end
    checks++;
    if (err_cnt - e0 !== xe) begin
      failures++;
      $display("FAIL %s err byte=%h got=%0d want=%0d", tag, b, err_cnt - e0, xe);
    end
    checks++;
    if (dataout !== 7'(model_out)) begin
      failures++;
      $display("FAIL %s dataout got=%0d want=%0d", tag, dataout, model_out);
    end
    checks++;
    if (led !== 7'(model_out)) begin
      failures++;
      $display("FAIL %s LED got=%0d want=%0d", tag, led, model_out);
    end
  endtask

  task automatic quick(input logic [7:0] b, input string tag);
    send_byte(b, 8, 8, tag);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    if (n >= int'(TO)) model_clear();
  endtask

  task automatic check_zero(input string tag);
    checks++;
    if (dataout !== 7'd0 || led !== 7'd0 || dav !== 1'b0 || err !== 1'b0) begin
      failures++;
      $display("FAIL %s got dataout=%0d LED=%0d dav=%b err=%b want all zero",
               tag, dataout, led, dav, err);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rdrdy = 1'b0;
    rbr   = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    model_clear();
    model_out = 0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check_zero("post_reset");
  endtask

  task automatic test_valid();
    quick(8'h34, "valid_4");
    quick(8'h35, "valid_5");
    quick(CR,    "valid_cr");
    send_byte(8'h30, 12, 6, "lead0_0");
    quick(8'h39, "lead0_9");
    quick(CR,    "lead0_cr");
    quick(8'h39, "max_9");
    quick(8'h30, "max_0");
    quick(CR,    "max_cr");
    quick(8'h34, "ret45_4");
    quick(8'h35, "ret45_5");
    quick(CR,    "ret45_cr");
  endtask

  task automatic test_range();
    quick(8'h39, "range_9");
    quick(8'h31, "range_1");
    quick(CR,    "range_cr");
  endtask

  task automatic test_three_digits();
    quick(8'h31, "three_1");
    quick(8'h32, "three_2");
    quick(8'h33, "three_3");
    quick(CR,    "three_cr");
    quick(8'h37, "after_7");
    quick(CR,    "after_cr");
  endtask

  task automatic test_other();
    quick(8'h41, "oth_A");
    quick(CR,    "oth_cr");
    quick(CR,    "lone_cr");
    quick(8'h38, "idle_chk_8");
    quick(CR,    "idle_chk_cr");
  endtask

  task automatic test_timeout();
    quick(8'h35, "to_5");
    idle(150);
    quick(8'h33, "to_3");
    quick(CR,    "to_cr");
    quick(8'h5A, "to_disc_Z");
    idle(150);
    quick(8'h34, "to_disc_4");
    quick(CR,    "to_disc_cr");
  endtask

  task automatic test_reset_mid_entry();
    quick(8'h36, "rst_6");
    #3 rst_n = 1'b0;
    @(negedge clk);
    check_zero("mid_reset");
    repeat (5) @(posedge clk);
    @(negedge clk);
    check_zero("mid_reset_hold");
    rst_n = 1'b1;
    model_clear();
    model_out = 0;
    repeat (3) @(posedge clk);
    quick(CR,    "rst_cr_empty");
    quick(8'h32, "rst_2");
    quick(CR,    "rst_cr");
  endtask

  task automatic test_held_level();
    send_byte(8'h35, 5000, 8, "held_5");
    quick(8'h33, "held_3");
    quick(CR,    "held_cr");
  endtask

  task automatic test_random();
    logic [7:0] b;
    int r;
    for (int i = 0; i < 120; i++) begin
      r = int'($urandom_range(0, 9));
      if (r <= 5) begin
        b = 8'h30 + 8'($urandom_range(0, 9));
      end else if (r <= 7) begin
        b = CR;
      end else begin
        b = 8'($urandom_range(0, 255));
        if ((b >= 8'h30 && b <= 8'h39) || b == CR) b = 8'h41;
      end
      send_byte(b, int'($urandom_range(4, 20)), int'($urandom_range(4, 12)), "random");
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    dav_cnt  = 0;
    err_cnt  = 0;
    both_cnt = 0;
    model_out = 0;
    disc      = 1'b0;
    test_reset();
    test_valid();
    test_range();
    test_three_digits();
    test_other();
    test_timeout();
    test_reset_mid_entry();
    test_held_level();
    test_random();
    checks++;
    if (both_cnt !== 0) begin
      failures++;
      $display("FAIL dav_err_overlap got=%0d cycles want=0", both_cnt);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
